// File: rtl/cache_controller.sv
// Read-miss sequencing controller for a direct-mapped cache with one-word CPU reads,
// line refill from RAM over a req/ack handshake, and saturating hit/miss counters.
//
// state     | meaning
// S_IDLE    | waiting for cpu_req; cache_address follows cpu_addr
// S_LOOKUP  | tag compare on the latched address
// S_MISS    | ram_req held until ram_ack delivers the line
// S_FILL    | fetched line written into the cache
// S_RESPOND | cpu_ready pulse with cpu_rdata valid
module cache_controller (
    input  logic         globalclock,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic [14:0]  cpu_addr,
    output logic         cpu_ready,
    output logic [31:0]  cpu_rdata,
    output logic         busy,
    output logic         cache_wrEn,
    output logic [14:0]  cache_address,
    output logic [127:0] cache_inData,
    input  logic [31:0]  cache_outData,
    input  logic         cache_hit,
    output logic         ram_req,
    output logic [12:0]  ram_addr,
    input  logic         ram_ack,
    input  logic [127:0] ram_rdata,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_MISS    = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;

    logic [2:0]   r_state;
    logic [14:0]  r_addr;
    logic [127:0] r_line;
    logic         r_refill;
    logic [31:0]  r_rdata;
    logic [15:0]  r_hit_cnt;
    logic [15:0]  r_miss_cnt;

    always_ff @(posedge globalclock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_line     <= '0;
            r_refill   <= 1'b0;
            r_rdata    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_addr   <= cpu_addr;
                        r_refill <= 1'b0;
                        r_state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        r_rdata <= cache_outData;
                        // the post-fill re-lookup is not a hit from the CPU's point of view
                        if (!r_refill && (r_hit_cnt != 16'hFFFF))
                            r_hit_cnt <= r_hit_cnt + 16'd1;
                        r_state <= S_RESPOND;
                    end else begin
                        if (r_miss_cnt != 16'hFFFF)
                            r_miss_cnt <= r_miss_cnt + 16'd1;
                        r_state <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (ram_ack) begin
                        r_line  <= ram_rdata;
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_refill <= 1'b1;
                    r_state  <= S_LOOKUP;
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_ready     = (r_state == S_RESPOND);
    assign cpu_rdata     = r_rdata;
    assign busy          = (r_state != S_IDLE);
    assign cache_wrEn    = (r_state == S_FILL);
    assign cache_address = (r_state == S_IDLE) ? cpu_addr : r_addr;
    assign cache_inData  = r_line;
    assign ram_req       = (r_state == S_MISS);
    assign ram_addr      = r_addr[14:2];
    assign hit_cnt       = r_hit_cnt;
    assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller with a behavioural cache, RAM responder
// and a tag-level reference model of expected hits, misses and returned words.
module tb_cache_controller;

    logic         globalclock;
    logic         reset;
    logic         cpu_req;
    logic [14:0]  cpu_addr;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         busy;
    logic         cache_wrEn;
    logic [14:0]  cache_address;
    logic [127:0] cache_inData;
    logic [31:0]  cache_outData;
    logic         cache_hit;
    logic         ram_req;
    logic [12:0]  ram_addr;
    logic         ram_ack;
    logic [127:0] ram_rdata;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    cache_controller dut (
        .globalclock   (globalclock),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_ready     (cpu_ready),
        .cpu_rdata     (cpu_rdata),
        .busy          (busy),
        .cache_wrEn    (cache_wrEn),
        .cache_address (cache_address),
        .cache_inData  (cache_inData),
        .cache_outData (cache_outData),
        .cache_hit     (cache_hit),
        .ram_req       (ram_req),
        .ram_addr      (ram_addr),
        .ram_ack       (ram_ack),
        .ram_rdata     (ram_rdata),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    initial globalclock = 1'b0;
    always #5 globalclock = ~globalclock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ram_line(input logic [12:0] la);
        if (la == 13'h0401) return 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
        return {la, 3'd0, 16'hA5A5, la, 3'd1, 16'h5A5A, la, 3'd2, 16'h3C3C, la, 3'd3, 16'hC3C3};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] ln, input logic [1:0] off);
        case (off)
            2'd0:    return ln[127:96];
            2'd1:    return ln[95:64];
            2'd2:    return ln[63:32];
            default: return ln[31:0];
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // behavioural cache array seen by the DUT
    logic         env_valid [0:1023];
    logic [2:0]   env_tag   [0:1023];
    logic [127:0] env_data  [0:1023];
    logic [9:0]   w_idx;
    int           wr_count = 0;

    assign w_idx = cache_address[11:2];
    always_comb begin
        cache_hit     = env_valid[w_idx] && (env_tag[w_idx] == cache_address[14:12]);
        cache_outData = word_of(env_data[w_idx], cache_address[1:0]);
    end

    always @(posedge globalclock) begin
        if (cache_wrEn) begin
            env_valid[w_idx] <= 1'b1;
            env_tag[w_idx]   <= cache_address[14:12];
            env_data[w_idx]  <= cache_inData;
            wr_count         <= wr_count + 1;
        end
    end

    // reference model: what the cache should hold, and counter expectations
    bit          ref_valid [0:1023];
    logic [2:0]  ref_tag   [0:1023];
    logic [15:0] hit_exp  = '0;
    logic [15:0] miss_exp = '0;
    logic [31:0] exp_q [$];

    // RAM responder
    int          ack_delay = 0;
    int          ack_hold = 0;
    int          req_cycles = 0;
    int          wait_cnt = -1;
    int          hold_left = 0;
    logic [12:0] exp_line_addr = '0;

    initial begin
        ram_ack   = 1'b0;
        ram_rdata = '0;
        forever begin
            @(negedge globalclock);
            if (ram_req) req_cycles++;
            if (!reset) begin
                ram_ack  = 1'b0;
                wait_cnt = -1;
            end else if (ram_ack) begin
                if (hold_left > 0) hold_left--;
                else ram_ack = 1'b0;
            end else if (ram_req) begin
                if (wait_cnt < 0) wait_cnt = ack_delay;
                if (wait_cnt == 0) begin
                    check("ram_addr", 32'(ram_addr), 32'(exp_line_addr));
                    ram_ack   = 1'b1;
                    ram_rdata = ram_line(ram_addr);
                    hold_left = ack_hold;
                    wait_cnt  = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // monitor: every cpu_ready consumes one expected word
    initial begin
        forever begin
            @(negedge globalclock);
            if (cpu_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", cpu_rdata, 32'hXXXX_XXXX ^ cpu_rdata ^ 32'h1);
                end else begin
                    check("cpu_rdata", cpu_rdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [14:0] a, input int dly, input int hold, input bit poke);
        bit          hit;
        int          n;
        int          wr0;
        int          rq0;
        logic [9:0]  idx;
        idx = a[11:2];
        @(negedge globalclock);
        check("idle_before_req", 32'(busy), 32'd0);
        hit = ref_valid[idx] && (ref_tag[idx] == a[14:12]);
        if (hit) begin
            hit_exp = sat_inc(hit_exp);
        end else begin
            miss_exp       = sat_inc(miss_exp);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[14:12];
        end
        exp_q.push_back(word_of(ram_line(a[14:2]), a[1:0]));
        ack_delay     = dly;
        ack_hold      = hold;
        exp_line_addr = a[14:2];
        wr0           = wr_count;
        rq0           = req_cycles;
        cpu_req       = 1'b1;
        cpu_addr      = a;
        @(negedge globalclock);
        cpu_req  = 1'b0;
        cpu_addr = 15'($urandom);
        n = 1;
        while (!cpu_ready && n < 300) begin
            if (!busy) check("busy_during_req", 32'(busy), 32'd1);
            if (poke && n == 3) begin
                cpu_req  = 1'b1;
                cpu_addr = a ^ 15'h7FFF;
            end else begin
                cpu_req  = 1'b0;
            end
            @(negedge globalclock);
            n++;
        end
        cpu_req = 1'b0;
        if (n >= 300) check("ready_timeout", 32'(n), 32'd0);
        check("latency", 32'(n), hit ? 32'd2 : 32'(5 + dly));
        check("busy_at_ready", 32'(busy), 32'd1);
        @(negedge globalclock);
        check("busy_after", 32'(busy), 32'd0);
        check("hit_cnt", 32'(hit_cnt), 32'(hit_exp));
        check("miss_cnt", 32'(miss_cnt), 32'(miss_exp));
        check("cache_writes", 32'(wr_count - wr0), hit ? 32'd0 : 32'd1);
        check("ram_req_cycles", 32'(req_cycles - rq0), hit ? 32'd0 : 32'(dly + 1));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_valid[i] = 1'b0;
            env_tag[i]   = '0;
            env_data[i]  = '0;
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        reset    = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        repeat (2) @(negedge globalclock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_req", 32'(ram_req), 32'd0);
        check("rst_wren", 32'(cache_wrEn), 32'd0);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        reset = 1'b1;

        issue(15'h1005, 0, 0, 1'b0);
        issue(15'h1007, 0, 0, 1'b0);
        issue(15'h5005, 0, 1, 1'b0);
        issue(15'h1005, 1, 0, 1'b0);
        issue(15'h1006, 10, 2, 1'b1);
        repeat (4) @(negedge globalclock);

        for (int i = 0; i < 40; i++) begin
            issue({3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'($urandom)},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
        end

        // reset in the middle of the RAM handshake
        @(negedge globalclock);
        ack_delay     = 30;
        exp_line_addr = 15'h2abc >> 2;
        cpu_req       = 1'b1;
        cpu_addr      = 15'h2abc;
        @(negedge globalclock);
        cpu_req = 1'b0;
        repeat (3) @(negedge globalclock);
        check("pre_reset_ram_req", 32'(ram_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ram_req", 32'(ram_req), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_hit", 32'(hit_cnt), 32'd0);
        check("async_rst_miss", 32'(miss_cnt), 32'd0);
        hit_exp  = '0;
        miss_exp = '0;
        @(negedge globalclock);
        reset = 1'b1;
        issue(15'h2abc, 0, 0, 1'b0);

        // saturation of the hit counter
        @(negedge globalclock);
        force dut.r_hit_cnt = 16'hFFFE;
        #1 release dut.r_hit_cnt;
        hit_exp = 16'hFFFE;
        issue(15'h2abc, 0, 0, 1'b0);
        issue(15'h2abd, 0, 0, 1'b0);
        issue(15'h2abe, 0, 0, 1'b0);
        check("hit_saturated", 32'(hit_cnt), 32'h0000FFFF);

        repeat (5) @(negedge globalclock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
